// File: rtl/timer_ctrl_seq.sv
// Avalon-MM master that sequences an interval timer's 16-bit slave port for one requester.
// Expands start/stop/snapshot commands into register accesses and services the timeout irq.
module timer_ctrl_seq #(
  parameter int TICK_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [31:0]           cmd_period,
  input  logic                  cmd_continuous,
  output logic                  snap_valid,
  output logic [31:0]           snap_value,
  output logic                  tick,
  output logic [TICK_CNT_W-1:0] tick_count,
  output logic                  busy,
  output logic [2:0]            tmr_address,
  output logic                  tmr_chipselect,
  output logic                  tmr_write_n,
  output logic [15:0]           tmr_writedata,
  input  logic [15:0]           tmr_readdata,
  input  logic                  tmr_irq
);

  typedef enum logic [3:0] {
    IDLE, STOP_WR, PL_WR, PH_WR, CTRL_WR, SNAP_WR, RD_L, RD_H, RD_DONE, IRQ_CLR
  } state_t;

  state_t                  state_q, state_d;
  logic [31:0]             period_q, period_d;
  logic                    cont_q, cont_d;
  logic [2:0]              tmr_address_q, tmr_address_d;
  logic                    tmr_chipselect_q, tmr_chipselect_d;
  logic                    tmr_write_n_q, tmr_write_n_d;
  logic [15:0]             tmr_writedata_q, tmr_writedata_d;
  logic [31:0]             snap_value_q, snap_value_d;
  logic                    snap_valid_q, snap_valid_d;
  logic                    tick_q, tick_d;
  logic [TICK_CNT_W-1:0]   tick_count_q, tick_count_d;
  logic                    cmd_fire;

  assign cmd_ready = (state_q == IDLE) && !tmr_irq;
  assign cmd_fire  = cmd_valid && cmd_ready;

  always_comb begin
    state_d          = state_q;
    period_d         = period_q;
    cont_d           = cont_q;
    snap_value_d     = snap_value_q;
    snap_valid_d     = 1'b0;
    tick_d           = 1'b0;
    tick_count_d     = tick_count_q;
    tmr_chipselect_d = 1'b0;
    tmr_write_n_d    = 1'b1;
    tmr_address_d    = 3'd0;
    tmr_writedata_d  = 16'h0000;

    unique case (state_q)
      IDLE: begin
        if (tmr_irq) begin
          state_d = IRQ_CLR;
        end else if (cmd_fire) begin
          period_d = cmd_period;
          cont_d   = cmd_continuous;
          unique case (cmd_op)
            2'd0:    state_d = STOP_WR;
            2'd1:    state_d = CTRL_WR;
            2'd2:    state_d = SNAP_WR;
            default: state_d = IDLE;
          endcase
        end
      end
      STOP_WR: state_d = PL_WR;
      PL_WR:   state_d = PH_WR;
      PH_WR:   state_d = CTRL_WR;
      CTRL_WR: state_d = IDLE;
      SNAP_WR: state_d = RD_L;
      RD_L:    state_d = RD_H;
      RD_H: begin
        state_d            = RD_DONE;
        snap_value_d[15:0] = tmr_readdata;
      end
      RD_DONE: begin
        state_d             = IDLE;
        snap_value_d[31:16] = tmr_readdata;
        snap_valid_d        = 1'b1;
      end
      IRQ_CLR: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Bus outputs are registered from the next state so they line up with the state they belong to.
    unique case (state_d)
      STOP_WR: begin
        tmr_chipselect_d = 1'b1;
        tmr_write_n_d    = 1'b0;
        tmr_address_d    = 3'd1;
        tmr_writedata_d  = 16'h0008;
      end
      PL_WR: begin
        tmr_chipselect_d = 1'b1;
        tmr_write_n_d    = 1'b0;
        tmr_address_d    = 3'd2;
        tmr_writedata_d  = period_q[15:0];
      end
      PH_WR: begin
        tmr_chipselect_d = 1'b1;
        tmr_write_n_d    = 1'b0;
        tmr_address_d    = 3'd3;
        tmr_writedata_d  = period_q[31:16];
      end
      CTRL_WR: begin
        tmr_chipselect_d = 1'b1;
        tmr_write_n_d    = 1'b0;
        tmr_address_d    = 3'd1;
        // Reached from PH_WR only on a start; directly from IDLE it is a stop.
        if (state_q == PH_WR) begin
          tmr_writedata_d = {13'h0000, 1'b1, cont_q, 1'b1};
          tick_count_d    = '0;
        end else begin
          tmr_writedata_d = 16'h0008;
        end
      end
      SNAP_WR: begin
        tmr_chipselect_d = 1'b1;
        tmr_write_n_d    = 1'b0;
        tmr_address_d    = 3'd4;
      end
      RD_L: begin
        tmr_chipselect_d = 1'b1;
        tmr_address_d    = 3'd4;
      end
      RD_H: begin
        tmr_chipselect_d = 1'b1;
        tmr_address_d    = 3'd5;
      end
      IRQ_CLR: begin
        tmr_chipselect_d = 1'b1;
        tmr_write_n_d    = 1'b0;
        tick_d           = 1'b1;
        tick_count_d     = tick_count_q + TICK_CNT_W'(1);
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= IDLE;
      period_q         <= 32'h0;
      cont_q           <= 1'b0;
      tmr_address_q    <= 3'd0;
      tmr_chipselect_q <= 1'b0;
      tmr_write_n_q    <= 1'b1;
      tmr_writedata_q  <= 16'h0000;
      snap_value_q     <= 32'h0;
      snap_valid_q     <= 1'b0;
      tick_q           <= 1'b0;
      tick_count_q     <= '0;
    end else begin
      state_q          <= state_d;
      period_q         <= period_d;
      cont_q           <= cont_d;
      tmr_address_q    <= tmr_address_d;
      tmr_chipselect_q <= tmr_chipselect_d;
      tmr_write_n_q    <= tmr_write_n_d;
      tmr_writedata_q  <= tmr_writedata_d;
      snap_value_q     <= snap_value_d;
      snap_valid_q     <= snap_valid_d;
      tick_q           <= tick_d;
      tick_count_q     <= tick_count_d;
    end
  end

  assign busy           = (state_q != IDLE);
  assign tmr_address    = tmr_address_q;
  assign tmr_chipselect = tmr_chipselect_q;
  assign tmr_write_n    = tmr_write_n_q;
  assign tmr_writedata  = tmr_writedata_q;
  assign snap_value     = snap_value_q;
  assign snap_valid     = snap_valid_q;
  assign tick           = tick_q;
  assign tick_count     = tick_count_q;

endmodule
